// File: rtl/hs32_pipe_ctl_pkg.sv
// Shared hs32 pipeline types: register index, pipe sequencer states and a
// small helper used by the sequencer.
package hs32_pipe_ctl_pkg;

    localparam int REG_W = 4;

    typedef logic [REG_W-1:0] hs32_reg_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hs32_pipe_state_e;

    // True when no stage holds a live instruction.
    function automatic logic pipe_empty(input logic v1, input logic v2, input logic v3);
        return ~(v1 | v2 | v3);
    endfunction

endpackage

// File: rtl/hs32_perf_cnt.sv
// Free-running event counter with synchronous reset; wraps modulo 2^W.
module hs32_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hs32_pipe_ctl.sv
// hs32 pipe sequencer: owns the IF/D1, S2 and S3 valid bits, stage enables,
// the rd2/rd3 hazard scoreboard, debug halt/drain and the perf counters.
module hs32_pipe_ctl
    import hs32_pipe_ctl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    output logic             d1_en_o,
    input  logic             d1_stall_i,
    input  logic [REG_W-1:0] d1_rd_i,
    input  logic             d1_wb_i,
    output logic             s2_en_o,
    output logic             s3_en_o,
    input  logic             mem_busy_i,
    input  logic             flush_i,
    output logic [REG_W-1:0] rd2_o,
    output logic [REG_W-1:0] rd3_o,
    output logic             stl2_o,
    output logic             stl3_o,
    output logic             retire_o,
    input  logic             halt_req_i,
    output logic             halt_ack_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    hs32_pipe_state_e state, state_nxt;

    logic      v1, v2, v3;
    logic      wb2, wb3;
    hs32_reg_t rd2, rd3;
    logic      flush_pend;

    logic frz;
    logic fl;
    logic adv1;
    logic stall_evt;

    // A memory wait freezes everything; a flush seen while frozen is parked
    // in flush_pend and takes effect on the first unfrozen cycle.
    assign frz  = mem_busy_i;
    assign fl   = (flush_i | flush_pend) & ~frz;
    assign adv1 = v1 & ~d1_stall_i & ~frz & ~fl;

    assign if_ready_o = (state == RUN) & ~frz & ~fl & (~v1 | adv1);
    assign d1_en_o    = if_valid_i & if_ready_o;
    assign s2_en_o    = adv1;
    assign s3_en_o    = ~frz;

    assign rd2_o      = rd2;
    assign rd3_o      = rd3;
    assign stl2_o     = v2 & wb2;
    assign stl3_o     = v3 & wb3;
    assign retire_o   = v3 & ~frz;
    assign halt_ack_o = (state == HALTED);
    assign stall_evt  = v1 & d1_stall_i & ~frz;

    // Valid bits. The S3 instruction is older than the branch and still
    // retires on a flush; only IF/D1 and S2 are killed.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            flush_pend <= 1'b0;
        end else if (frz) begin
            flush_pend <= flush_pend | flush_i;
        end else begin
            v1         <= (d1_en_o | (v1 & ~adv1)) & ~fl;
            v2         <= adv1;
            v3         <= v2 & ~fl;
            flush_pend <= 1'b0;
        end
    end

    // Destination scoreboard feeding decode1's RAW hazard check.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd2 <= '0;
            wb2 <= 1'b0;
            rd3 <= '0;
            wb3 <= 1'b0;
        end else if (!frz) begin
            if (adv1) begin
                rd2 <= d1_rd_i;
                wb2 <= d1_wb_i;
            end
            rd3 <= rd2;
            wb3 <= wb2 & v2 & ~fl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN only blocks fetch; in-flight work keeps moving until the pipe
    // is empty or the halt request is withdrawn.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        if (!frz) begin
            case (state)
                RUN: begin
                    if (halt_req_i) state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (!halt_req_i)                 state_nxt = RUN;
                    else if (pipe_empty(v1, v2, v3)) state_nxt = HALTED;
                end
                HALTED: begin
                    if (!halt_req_i) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    hs32_perf_cnt #(
        .W(CNT_W)
    ) u_retire_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (retire_o),
        .count(retire_cnt_o)
    );

    hs32_perf_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (stall_evt),
        .count(stall_cnt_o)
    );

endmodule

// File: tb/tb_hs32_pipe_ctl.sv
// Directed bench for hs32_pipe_ctl: retiring instructions are checked by a
// scoreboard monitor, cycle-exact control outputs by the stimulus thread.
module tb_hs32_pipe_ctl;
    import hs32_pipe_ctl_pkg::*;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_valid_i;
    logic             if_ready_o;
    logic             d1_en_o;
    logic             d1_stall_i;
    logic [REG_W-1:0] d1_rd_i;
    logic             d1_wb_i;
    logic             s2_en_o;
    logic             s3_en_o;
    logic             mem_busy_i;
    logic             flush_i;
    logic [REG_W-1:0] rd2_o;
    logic [REG_W-1:0] rd3_o;
    logic             stl2_o;
    logic             stl3_o;
    logic             retire_o;
    logic             halt_req_i;
    logic             halt_ack_o;
    logic [CNT_W-1:0] retire_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Fetch-side packet and the environment's IF/D1 register it loads into.
    logic [REG_W-1:0] fetch_rd;
    logic             fetch_wb;
    logic [REG_W-1:0] d1_rd_q;
    logic             d1_wb_q;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wb;
    } ret_t;

    ret_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hs32_pipe_ctl #(
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid_i  (if_valid_i),
        .if_ready_o  (if_ready_o),
        .d1_en_o     (d1_en_o),
        .d1_stall_i  (d1_stall_i),
        .d1_rd_i     (d1_rd_i),
        .d1_wb_i     (d1_wb_i),
        .s2_en_o     (s2_en_o),
        .s3_en_o     (s3_en_o),
        .mem_busy_i  (mem_busy_i),
        .flush_i     (flush_i),
        .rd2_o       (rd2_o),
        .rd3_o       (rd3_o),
        .stl2_o      (stl2_o),
        .stl3_o      (stl3_o),
        .retire_o    (retire_o),
        .halt_req_i  (halt_req_i),
        .halt_ack_o  (halt_ack_o),
        .retire_cnt_o(retire_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always @(posedge clk) begin
        if (reset) begin
            d1_rd_q <= '0;
            d1_wb_q <= 1'b0;
        end else if (d1_en_o) begin
            d1_rd_q <= fetch_rd;
            d1_wb_q <= fetch_wb;
        end
    end

    assign d1_rd_i = d1_rd_q;
    assign d1_wb_i = d1_wb_q;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b, required %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid_i = 1'b0;
        fetch_rd   = '0;
        fetch_wb   = 1'b0;
        d1_stall_i = 1'b0;
        mem_busy_i = 1'b0;
        flush_i    = 1'b0;
        halt_req_i = 1'b0;
    endtask

    task automatic present(input logic [REG_W-1:0] rd, input logic wb);
        if_valid_i = 1'b1;
        fetch_rd   = rd;
        fetch_wb   = wb;
    endtask

    // Scoreboard monitor: every retirement must match the oldest expected one.
    always @(negedge clk) begin
        ret_t e;
        if (!reset && retire_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL retire_unexpected: actual retire with rd3=%0d, required no retire", rd3_o);
            end else begin
                e = exp_q.pop_front();
                checkw("retire_rd", 32'(rd3_o), 32'(e.rd));
                check1("retire_wb", stl3_o, e.wb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t2_stall;
        logic [7:0] t2_rdy;
        logic [7:0] t2_s2en;
        logic [7:0] t2_stl2;

        idle();
        reset = 1'b1;
        tick();
        tick();

        // Reset state.
        @(negedge clk);
        check1("rst_if_ready", if_ready_o, 1'b1);
        check1("rst_s2_en", s2_en_o, 1'b0);
        check1("rst_s3_en", s3_en_o, 1'b1);
        check1("rst_stl2", stl2_o, 1'b0);
        check1("rst_stl3", stl3_o, 1'b0);
        check1("rst_retire", retire_o, 1'b0);
        check1("rst_halt_ack", halt_ack_o, 1'b0);
        checkw("rst_retire_cnt", retire_cnt_o, 32'd0);
        checkw("rst_stall_cnt", stall_cnt_o, 32'd0);
        tick();
        mem_busy_i = 1'b1;
        @(negedge clk);
        check1("rst_busy_s3_en", s3_en_o, 1'b0);
        check1("rst_busy_if_ready", if_ready_o, 1'b0);
        tick();
        reset      = 1'b0;
        mem_busy_i = 1'b0;

        // 1: three back-to-back fetches retire in cycles 4..6.
        for (int c = 1; c <= 7; c++) begin
            if (c <= 3) begin
                present(c[REG_W-1:0], (c != 2));
                exp_q.push_back('{rd: c[REG_W-1:0], wb: (c != 2)});
            end else begin
                if_valid_i = 1'b0;
            end
            @(negedge clk);
            check1($sformatf("t1_d1_en_c%0d", c), d1_en_o, (c <= 3));
            check1($sformatf("t1_retire_c%0d", c), retire_o, (c >= 4 && c <= 6));
            tick();
        end
        @(negedge clk);
        checkw("t1_retire_cnt", retire_cnt_o, 32'd3);
        tick();

        // 2: two-cycle decode stall on the second instruction.
        t2_stall = 8'b0000_1100;
        t2_rdy   = 8'b1111_0011;
        t2_s2en  = 8'b0011_0010;
        t2_stl2  = 8'b0110_0100;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                present(4'd4, 1'b1);
                exp_q.push_back('{rd: 4'd4, wb: 1'b1});
            end else if (k == 1) begin
                present(4'd5, 1'b1);
                exp_q.push_back('{rd: 4'd5, wb: 1'b1});
            end else if (k == 2) begin
                present(4'd6, 1'b1);
                exp_q.push_back('{rd: 4'd6, wb: 1'b1});
            end else if (k >= 5) begin
                if_valid_i = 1'b0;
            end
            d1_stall_i = t2_stall[k];
            @(negedge clk);
            check1($sformatf("t2_if_ready_k%0d", k), if_ready_o, t2_rdy[k]);
            check1($sformatf("t2_s2_en_k%0d", k), s2_en_o, t2_s2en[k]);
            check1($sformatf("t2_stl2_k%0d", k), stl2_o, t2_stl2[k]);
            tick();
        end
        d1_stall_i = 1'b0;
        @(negedge clk);
        checkw("t2_stall_cnt", stall_cnt_o, 32'd2);
        checkw("t2_retire_cnt", retire_cnt_o, 32'd6);
        tick();

        // 3: scoreboard slot progression for rd=5, wb=1.
        present(4'd5, 1'b1);
        exp_q.push_back('{rd: 4'd5, wb: 1'b1});
        tick();
        if_valid_i = 1'b0;
        @(negedge clk);
        check1("t3_s2_en", s2_en_o, 1'b1);
        tick();
        @(negedge clk);
        checkw("t3_rd2", 32'(rd2_o), 32'd5);
        check1("t3_stl2", stl2_o, 1'b1);
        tick();
        @(negedge clk);
        checkw("t3_rd3", 32'(rd3_o), 32'd5);
        check1("t3_stl3", stl3_o, 1'b1);
        check1("t3_stl2_clear", stl2_o, 1'b0);
        tick();
        tick();

        // 4: flush with all three stages full; only S3 retires.
        present(4'd7, 1'b1);
        exp_q.push_back('{rd: 4'd7, wb: 1'b1});
        tick();
        present(4'd8, 1'b1);
        tick();
        present(4'd9, 1'b1);
        tick();
        present(4'd10, 1'b1);
        flush_i = 1'b1;
        @(negedge clk);
        check1("t4_retire", retire_o, 1'b1);
        check1("t4_if_ready", if_ready_o, 1'b0);
        check1("t4_d1_en", d1_en_o, 1'b0);
        check1("t4_s2_en", s2_en_o, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check1("t4_stl2", stl2_o, 1'b0);
        check1("t4_stl3", stl3_o, 1'b0);
        check1("t4_retire_after", retire_o, 1'b0);
        check1("t4_if_ready_after", if_ready_o, 1'b1);
        tick();
        @(negedge clk);
        checkw("t4_retire_cnt", retire_cnt_o, 32'd8);
        tick();

        // 5: flush pulse inside a three-cycle freeze is deferred.
        present(4'd11, 1'b1);
        exp_q.push_back('{rd: 4'd11, wb: 1'b1});
        tick();
        present(4'd12, 1'b1);
        tick();
        present(4'd13, 1'b1);
        tick();
        for (int k = 3; k <= 5; k++) begin
            if_valid_i = 1'b0;
            mem_busy_i = 1'b1;
            flush_i    = (k == 4);
            @(negedge clk);
            check1($sformatf("t5_retire_k%0d", k), retire_o, 1'b0);
            check1($sformatf("t5_s3_en_k%0d", k), s3_en_o, 1'b0);
            check1($sformatf("t5_s2_en_k%0d", k), s2_en_o, 1'b0);
            check1($sformatf("t5_stl2_k%0d", k), stl2_o, 1'b1);
            check1($sformatf("t5_stl3_k%0d", k), stl3_o, 1'b1);
            tick();
        end
        mem_busy_i = 1'b0;
        flush_i    = 1'b0;
        present(4'd14, 1'b1);
        @(negedge clk);
        check1("t5_release_retire", retire_o, 1'b1);
        check1("t5_release_s3_en", s3_en_o, 1'b1);
        check1("t5_release_s2_en", s2_en_o, 1'b0);
        check1("t5_release_if_ready", if_ready_o, 1'b0);
        check1("t5_release_d1_en", d1_en_o, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check1("t5_after_stl2", stl2_o, 1'b0);
        check1("t5_after_retire", retire_o, 1'b0);
        check1("t5_after_if_ready", if_ready_o, 1'b1);
        checkw("t5_retire_cnt", retire_cnt_o, 32'd9);
        tick();

        // 6: debug halt with two instructions in flight.
        present(4'd13, 1'b1);
        exp_q.push_back('{rd: 4'd13, wb: 1'b1});
        tick();
        present(4'd14, 1'b0);
        exp_q.push_back('{rd: 4'd14, wb: 1'b0});
        tick();
        if_valid_i = 1'b0;
        halt_req_i = 1'b1;
        @(negedge clk);
        check1("t6_k2_if_ready", if_ready_o, 1'b1);
        check1("t6_k2_halt_ack", halt_ack_o, 1'b0);
        tick();
        present(4'd15, 1'b1);
        @(negedge clk);
        check1("t6_k3_if_ready", if_ready_o, 1'b0);
        check1("t6_k3_d1_en", d1_en_o, 1'b0);
        check1("t6_k3_halt_ack", halt_ack_o, 1'b0);
        tick();
        if_valid_i = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            check1($sformatf("t6_k%0d_halt_ack", k), halt_ack_o, (k >= 6));
            check1($sformatf("t6_k%0d_if_ready", k), if_ready_o, 1'b0);
            tick();
        end
        halt_req_i = 1'b0;
        @(negedge clk);
        check1("t6_k8_halt_ack", halt_ack_o, 1'b1);
        check1("t6_k8_if_ready", if_ready_o, 1'b0);
        tick();
        @(negedge clk);
        check1("t6_k9_halt_ack", halt_ack_o, 1'b0);
        check1("t6_k9_if_ready", if_ready_o, 1'b1);
        checkw("t6_retire_cnt", retire_cnt_o, 32'd11);
        checkw("t6_stall_cnt", stall_cnt_o, 32'd2);
        tick();

        // 7: reset mid-operation discards in-flight work and counters.
        present(4'd1, 1'b1);
        tick();
        present(4'd2, 1'b1);
        tick();
        idle();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check1("t7_stl2", stl2_o, 1'b0);
        check1("t7_s2_en", s2_en_o, 1'b0);
        checkw("t7_retire_cnt", retire_cnt_o, 32'd0);
        checkw("t7_stall_cnt", stall_cnt_o, 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check1($sformatf("t7_idle_retire_k%0d", k), retire_o, 1'b0);
            tick();
        end

        checkw("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
